core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_ready  in  1  instruction memory has data this cycle.
REQ-005 SHALL have port dmem_ready  in  1  data memory completed the access this cycle.
REQ-006 SHALL have port opcode  in  7  instruction bits [6:0] from the IR, valid from DECODE onward.
REQ-007 SHALL have port branch_taken  in  1  ALU compare result, sampled in EXEC.
REQ-008 SHALL have port imem_req  out  1  fetch request.
REQ-009 SHALL have port ir_write  out  1  latch instruction into the IR.
REQ-010 SHALL have ports dmem_req, dmem_we  out  1 each  data access request and write enable.
REQ-011 SHALL have ports reg_write, op_b, pc_write, pc_src  out  1 each  RF write, ALU B = immediate, PC update, PC = branch target.
REQ-012 SHALL have ports imm_sel  out  2 (0 = I, 1 = S, 2 = B) and wb_sel  out  2 (0 = ALU, 1 = memory).
REQ-013 SHALL have ports trap  out  1  illegal-opcode flag, and state  out  3  current FSM state.

Function
REQ-014 SHALL implement FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH.
REQ-015 FETCH: imem_req=1; wait while imem_ready=0; on imem_ready=1, ir_write=1 for that cycle, then DECODE.
REQ-016 DECODE: classify opcode as R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011; register the class; any other opcode -> TRAP; otherwise -> EXEC.
REQ-017 EXEC: op_b=1 for I/LOAD/STORE, 0 for R/BRANCH; imm_sel per class. R/I -> WB; LOAD/STORE -> MEM; BRANCH: pc_write=1, pc_src=branch_taken, then FETCH.
REQ-018 MEM: hold dmem_req=1 (dmem_we=1 for STORE) until dmem_ready=1. On ready, LOAD -> WB; STORE -> FETCH with pc_write=1, pc_src=0.
REQ-019 WB: reg_write=1, pc_write=1, pc_src=0, wb_sel=1 for LOAD, else 0; then FETCH.
REQ-020 TRAP: trap=1 and all other control outputs 0; the FSM SHALL stay in TRAP until reset.
REQ-021 Minimum latency with ready inputs already high SHALL be: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3.
REQ-022 Outputs SHALL be combinational from state and the registered class only; opcode SHALL be ignored outside DECODE.
REQ-023 A ready input asserted outside its own wait state SHALL have no effect.
REQ-024 Exactly one pc_write pulse SHALL occur per completed instruction; none SHALL occur for a trapped instruction.

Reset
REQ-025 rst=1 SHALL immediately force state=FETCH and class=R, and clear the retired count.
REQ-026 While rst=1, every output SHALL be 0, including imem_req.
REQ-027 Reset asserted in MEM or any wait SHALL drop dmem_req/imem_req in the same cycle; on release, fetch restarts cleanly.

Configuration
REQ-028 Macro CORE_SEQ_RETIRE_CNT_EN SHALL add output retired (CNT_W bits), incremented on every pc_write pulse and wrapping from all-ones to 0.
REQ-029 Without CORE_SEQ_RETIRE_CNT_EN, the retired port and counter logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package core_seq_pkg SHALL hold the state encodings, opcode constants, class enum, and imm_sel/wb_sel encodings.
REQ-031 Sub-module core_seq_decode SHALL be a combinational mapping from opcode to class plus illegal flag, instantiated once.

Verification
REQ-032 R-type 0110011 with imem_ready=1: states 0,1,2,4; reg_write=1 only in WB; pc_write once; retired +1.
REQ-033 LOAD with dmem_ready low for 3 MEM cycles: dmem_req=1 for 4 cycles, dmem_we=0, then WB with wb_sel=1; total 8 cycles.
REQ-034 BRANCH with branch_taken=1: pc_write=1 and pc_src=1 in EXEC, reg_write never asserted; 3 cycles.
REQ-035 opcode 1111111 in DECODE: TRAP, trap=1, and the state stays 5 for 20 cycles with no pc_write.
REQ-036 rst pulse mid-MEM of a STORE: dmem_req falls in the same cycle; after release, state=0 and imem_req=1.
REQ-037 With CORE_SEQ_RETIRE_CNT_EN and CNT_W=4: 17 R-type instructions give retired=1 (wrap).

Source files
------------

// File: rtl/core_seq_pkg.sv
// Shared encodings for the core sequencer: FSM states, opcodes, instruction
// classes and the imm_sel / wb_sel codes driven to the datapath.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } instr_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] IMM_I  = 2'd0;
    localparam logic [1:0] IMM_S  = 2'd1;
    localparam logic [1:0] IMM_B  = 2'd2;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;

    // Immediate format used by each class; R-type does not read it.
    function automatic logic [1:0] imm_sel_for(input instr_class_t c);
        logic [1:0] sel;
        case (c)
            CLS_STORE:  sel = IMM_S;
            CLS_BRANCH: sel = IMM_B;
            default:    sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Control bus between the core sequencer (master) and the datapath/memories (slave).
interface core_sequencer_if;

    logic       imem_ready;
    logic       dmem_ready;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       imem_req;
    logic       ir_write;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic       op_b;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] imm_sel;
    logic [1:0] wb_sel;
    logic       trap;
    logic [2:0] state;

    modport master (
        input  imem_ready, dmem_ready, opcode, branch_taken,
        output imem_req, ir_write, dmem_req, dmem_we, reg_write, op_b,
               pc_write, pc_src, imm_sel, wb_sel, trap, state
    );

    modport slave (
        output imem_ready, dmem_ready, opcode, branch_taken,
        input  imem_req, ir_write, dmem_req, dmem_we, reg_write, op_b,
               pc_write, pc_src, imm_sel, wb_sel, trap, state
    );

endinterface

// File: rtl/core_seq_decode.sv
// Combinational opcode classifier: maps opcode[6:0] to an instruction class
// and flags anything outside the supported set as illegal.
module core_seq_decode
    import core_seq_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t iclass,
    output logic         illegal
);

    // Opcode to class lookup.
    always_comb begin
        iclass  = CLS_R;
        illegal = 1'b0;
        case (opcode)
            OP_R:      iclass = CLS_R;
            OP_I:      iclass = CLS_I;
            OP_LOAD:   iclass = CLS_LOAD;
            OP_STORE:  iclass = CLS_STORE;
            OP_BRANCH: iclass = CLS_BRANCH;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for a small RISC-V style core.
// Optional retired-instruction counter enabled by CORE_SEQ_RETIRE_CNT_EN.
module core_sequencer
    import core_seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef CORE_SEQ_RETIRE_CNT_EN
    output logic [CNT_W-1:0] retired,
`endif
    core_sequencer_if.master bus
);

    state_t       state_q;
    state_t       state_nx;
    instr_class_t iclass_q;
    instr_class_t iclass_nx;
    instr_class_t dec_class;
    logic         dec_illegal;

    logic       imem_req_raw;
    logic       ir_write_raw;
    logic       dmem_req_raw;
    logic       dmem_we_raw;
    logic       reg_write_raw;
    logic       op_b_raw;
    logic       pc_write_raw;
    logic       pc_src_raw;
    logic [1:0] imm_sel_raw;
    logic [1:0] wb_sel_raw;
    logic       trap_raw;

    core_seq_decode u_decode (
        .opcode  (bus.opcode),
        .iclass  (dec_class),
        .illegal (dec_illegal)
    );

    // State and latched instruction class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            iclass_q <= CLS_R;
        end else begin
            state_q  <= state_nx;
            iclass_q <= iclass_nx;
        end
    end

    // Next-state and control decode from state and latched class.
    always_comb begin
        state_nx      = state_q;
        iclass_nx     = iclass_q;
        imem_req_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        dmem_req_raw  = 1'b0;
        dmem_we_raw   = 1'b0;
        reg_write_raw = 1'b0;
        op_b_raw      = 1'b0;
        pc_write_raw  = 1'b0;
        pc_src_raw    = 1'b0;
        imm_sel_raw   = IMM_I;
        wb_sel_raw    = WB_ALU;
        trap_raw      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_raw = 1'b1;
                if (bus.imem_ready) begin
                    ir_write_raw = 1'b1;
                    state_nx     = ST_DECODE;
                end else begin
                    state_nx = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_nx = ST_TRAP;
                end else begin
                    iclass_nx = dec_class;
                    state_nx  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                op_b_raw    = (iclass_q != CLS_R) && (iclass_q != CLS_BRANCH);
                imm_sel_raw = imm_sel_for(iclass_q);
                case (iclass_q)
                    CLS_R, CLS_I:        state_nx = ST_WB;
                    CLS_LOAD, CLS_STORE: state_nx = ST_MEM;
                    CLS_BRANCH: begin
                        pc_write_raw = 1'b1;
                        pc_src_raw   = bus.branch_taken;
                        state_nx     = ST_FETCH;
                    end
                    default:             state_nx = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                dmem_req_raw = 1'b1;
                dmem_we_raw  = (iclass_q == CLS_STORE);
                if (!bus.dmem_ready) begin
                    state_nx = ST_MEM;
                end else if (iclass_q == CLS_LOAD) begin
                    state_nx = ST_WB;
                end else begin
                    // A store retires straight out of MEM.
                    pc_write_raw = 1'b1;
                    state_nx     = ST_FETCH;
                end
            end
            ST_WB: begin
                reg_write_raw = 1'b1;
                pc_write_raw  = 1'b1;
                wb_sel_raw    = (iclass_q == CLS_LOAD) ? WB_MEM : WB_ALU;
                state_nx      = ST_FETCH;
            end
            ST_TRAP: begin
                trap_raw = 1'b1;
                state_nx = ST_TRAP;
            end
            default: state_nx = ST_FETCH;
        endcase
    end

    // Reset masks every output combinationally so requests drop in the same cycle.
    assign bus.imem_req  = imem_req_raw  & ~rst;
    assign bus.ir_write  = ir_write_raw  & ~rst;
    assign bus.dmem_req  = dmem_req_raw  & ~rst;
    assign bus.dmem_we   = dmem_we_raw   & ~rst;
    assign bus.reg_write = reg_write_raw & ~rst;
    assign bus.op_b      = op_b_raw      & ~rst;
    assign bus.pc_write  = pc_write_raw  & ~rst;
    assign bus.pc_src    = pc_src_raw    & ~rst;
    assign bus.imm_sel   = imm_sel_raw   & {2{~rst}};
    assign bus.wb_sel    = wb_sel_raw    & {2{~rst}};
    assign bus.trap      = trap_raw      & ~rst;
    assign bus.state     = state_q       & {3{~rst}};

`ifdef CORE_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q;

    // Retired-instruction counter, one step per pc_write pulse, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= {CNT_W{1'b0}};
        end else if (pc_write_raw) begin
            retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_q <= retired_q;
        end
    end

    assign retired = retired_q & {CNT_W{~rst}};
`else
    logic cnt_w_unused;
    assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-instruction model expands each
// instruction into its expected cycle-by-cycle trace, checked every cycle.
module tb_core_sequencer;

    localparam int TB_CNT_W = 4;

    logic clk;
    logic rst;
`ifdef CORE_SEQ_RETIRE_CNT_EN
    logic [TB_CNT_W-1:0] retired;
`endif

    core_sequencer_if bus ();

    core_sequencer #(.CNT_W(TB_CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef CORE_SEQ_RETIRE_CNT_EN
        .retired (retired),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       imem_ready;
        logic       dmem_ready;
        logic       branch_taken;
        logic [6:0] opcode;
        logic [2:0] st;
        logic       imem_req, ir_write, dmem_req, dmem_we, reg_write;
        logic       op_b, pc_write, pc_src, trap;
        logic [1:0] imm_sel, wb_sel;
    } step_t;

    step_t trace[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cur = 0;
    bit    active = 1'b0;
    int    dut_pulses = 0;
    int    done_since_rst = 0;
    string tag = "reset";

    function automatic step_t blank(input logic noise);
        step_t s;
        s.imem_ready = noise;   s.dmem_ready = noise;   s.branch_taken = noise;
        s.opcode = 7'h7F;
        s.st = 3'd0;
        s.imem_req = 1'b0; s.ir_write = 1'b0; s.dmem_req = 1'b0; s.dmem_we = 1'b0;
        s.reg_write = 1'b0; s.op_b = 1'b0; s.pc_write = 1'b0; s.pc_src = 1'b0;
        s.trap = 1'b0; s.imm_sel = 2'd0; s.wb_sel = 2'd0;
        return s;
    endfunction

    // Model: expand one instruction into its expected trace.
    task automatic gen_instr(input logic [6:0] op, input int iwait, input int dwait,
                             input logic taken, input logic noise, input int trap_cycles);
        step_t s;
        bit is_r, is_i, is_ld, is_st, is_br, legal;
        is_r  = (op == 7'b0110011);
        is_i  = (op == 7'b0010011);
        is_ld = (op == 7'b0000011);
        is_st = (op == 7'b0100011);
        is_br = (op == 7'b1100011);
        legal = is_r | is_i | is_ld | is_st | is_br;
        for (int k = 0; k < iwait; k++) begin
            s = blank(noise); s.imem_ready = 1'b0; s.imem_req = 1'b1; trace.push_back(s);
        end
        s = blank(noise); s.imem_ready = 1'b1; s.imem_req = 1'b1; s.ir_write = 1'b1;
        trace.push_back(s);
        s = blank(noise); s.opcode = op; s.st = 3'd1; trace.push_back(s);
        if (!legal) begin
            for (int k = 0; k < trap_cycles; k++) begin
                s = blank(1'b1); s.st = 3'd5; s.trap = 1'b1; trace.push_back(s);
            end
            return;
        end
        s = blank(noise); s.st = 3'd2;
        s.op_b = is_i | is_ld | is_st;
        s.imm_sel = is_st ? 2'd1 : (is_br ? 2'd2 : 2'd0);
        if (is_br) begin
            s.branch_taken = taken; s.pc_write = 1'b1; s.pc_src = taken;
        end
        trace.push_back(s);
        if (is_ld | is_st) begin
            for (int k = 0; k <= dwait; k++) begin
                s = blank(noise); s.st = 3'd3; s.dmem_req = 1'b1; s.dmem_we = is_st;
                s.dmem_ready = (k == dwait);
                s.pc_write = (k == dwait) && is_st;
                trace.push_back(s);
            end
        end
        if (is_r | is_i | is_ld) begin
            s = blank(noise); s.st = 3'd4; s.reg_write = 1'b1; s.pc_write = 1'b1;
            s.wb_sel = is_ld ? 2'd1 : 2'd0;
            trace.push_back(s);
        end
        done_since_rst++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        bus.branch_taken = 1'b0; bus.opcode = 7'h00;
    endtask

    task automatic run_trace();
        for (int i = 0; i < trace.size(); i++) begin
            @(posedge clk); #1;
            bus.imem_ready   = trace[i].imem_ready;
            bus.dmem_ready   = trace[i].dmem_ready;
            bus.branch_taken = trace[i].branch_taken;
            bus.opcode       = trace[i].opcode;
            cur = i;
            active = 1'b1;
        end
        @(posedge clk); #1;
        active = 1'b0;
        idle_inputs();
        trace.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        done_since_rst = 0;
    endtask

    function automatic logic [15:0] pack_act();
        return {bus.state, bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_we,
                bus.reg_write, bus.op_b, bus.pc_write, bus.pc_src,
                bus.imm_sel, bus.wb_sel, bus.trap};
    endfunction

    // Per-cycle compare against the model trace.
    always @(negedge clk) begin
        if (active) begin
            logic [15:0] e;
            e = {trace[cur].st, trace[cur].imem_req, trace[cur].ir_write,
                 trace[cur].dmem_req, trace[cur].dmem_we, trace[cur].reg_write,
                 trace[cur].op_b, trace[cur].pc_write, trace[cur].pc_src,
                 trace[cur].imm_sel, trace[cur].wb_sel, trace[cur].trap};
            n_checks++;
            if (pack_act() !== e) begin
                n_fail++;
                $display("FAIL %s step %0d: got %h expected %h", tag, cur, pack_act(), e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.pc_write === 1'b1) dut_pulses++;
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("reset_outputs", {16'd0, pack_act()}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_since_rst = 0;
        #1;
        chk("post_reset_state", {29'd0, bus.state}, 32'd0);
        chk("post_reset_imem_req", {31'd0, bus.imem_req}, 32'd1);

        tag = "r_type";   gen_instr(7'b0110011, 0, 0, 1'b0, 1'b1, 0);
        chk("r_len", trace.size(), 32'd4);      run_trace();
        chk("r_pulses", dut_pulses, 32'd1);
        tag = "i_wait";   gen_instr(7'b0010011, 2, 0, 1'b0, 1'b0, 0);
        chk("i_len", trace.size(), 32'd6);      run_trace();
        tag = "load_w3";  gen_instr(7'b0000011, 0, 3, 1'b0, 1'b1, 0);
        chk("load_len", trace.size(), 32'd8);   run_trace();
        tag = "store";    gen_instr(7'b0100011, 0, 0, 1'b0, 1'b1, 0);
        chk("store_len", trace.size(), 32'd4);  run_trace();
        tag = "store_w2"; gen_instr(7'b0100011, 1, 2, 1'b0, 1'b0, 0);
        chk("store_w_len", trace.size(), 32'd7); run_trace();
        tag = "br_taken"; gen_instr(7'b1100011, 0, 0, 1'b1, 1'b0, 0);
        chk("br_len", trace.size(), 32'd3);     run_trace();
        tag = "br_not";   gen_instr(7'b1100011, 0, 0, 1'b0, 1'b1, 0);
        run_trace();
        chk("pulses_after_7", dut_pulses, 32'd7);
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("retired_7", {28'd0, retired}, 32'd7);
`endif

        tag = "trap";     gen_instr(7'b1111111, 0, 0, 1'b0, 1'b1, 20);
        chk("trap_len", trace.size(), 32'd22);  run_trace();
        #1;
        chk("trap_stays", {29'd0, bus.state}, 32'd5);
        chk("trap_no_pulse", dut_pulses, 32'd7);
        do_reset();
        #1;
        chk("trap_reset_state", {29'd0, bus.state}, 32'd0);
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("retired_cleared", {28'd0, retired}, 32'd0);
`endif

        tag = "store_rst"; gen_instr(7'b0100011, 0, 2, 1'b0, 1'b0, 0);
        void'(trace.pop_back());
        done_since_rst = 0;
        run_trace();
        chk("mid_mem_req", {31'd0, bus.dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_drops_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("rst_outputs_zero", {16'd0, pack_act()}, 32'd0);
        @(negedge clk);
        chk("rst_hold_zero", {16'd0, pack_act()}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("restart_state", {29'd0, bus.state}, 32'd0);
        chk("restart_imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("store_rst_no_pulse", dut_pulses, 32'd7);

        tag = "r_x17";
        for (int n = 0; n < 17; n++) begin
            gen_instr(7'b0110011, 0, 0, 1'b0, n[0], 0);
            run_trace();
        end
        chk("pulses_after_17", dut_pulses, 32'd24);
`ifdef CORE_SEQ_RETIRE_CNT_EN
        chk("retired_wrap", {28'd0, retired}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
